// File: rtl/mcs6530_bus_master_pkg.sv
// Shared types for the mcs6530 bus master: FSM state encoding and the
// RS0/CS1 select patterns presented to the RRIOT responder.
package mcs6530_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic rs0;
    logic cs1;
  } sel_t;

  // Idle deselects both spaces; ROM needs RS0 low, RAM/IO/timer needs CS1 low.
  localparam sel_t SEL_IDLE = '{rs0: 1'b1, cs1: 1'b1};
  localparam sel_t SEL_ROM  = '{rs0: 1'b0, cs1: 1'b1};
  localparam sel_t SEL_RSEL = '{rs0: 1'b1, cs1: 1'b0};

endpackage

// File: rtl/mcs6530_bus_master_if.sv
// Request/response handshake plus the 6502-side RRIOT bus, bundled so the
// master and its host/responder see one connection.
interface mcs6530_bus_master_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic       req_rom;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  logic [9:0] A;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       OE;
  logic       we_n;
  logic       RS0;
  logic       CS1;
  logic       IRQ;
  logic       irq_rise;

  modport master (
    input  req_valid, req_we, req_rom, req_addr, req_wdata, rsp_ready,
           DO, OE, IRQ,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           A, DI, we_n, RS0, CS1, irq_rise
  );

  modport slave (
    output req_valid, req_we, req_rom, req_addr, req_wdata, rsp_ready,
           DO, OE, IRQ,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           A, DI, we_n, RS0, CS1, irq_rise
  );

endinterface

// File: rtl/mcs6530_bus_master.sv
// Single-outstanding bus initiator for the mcs6530: sequences one read or
// write per request, waits (bounded) for OE on reads, and edge-detects IRQ.
module mcs6530_bus_master
  import mcs6530_bus_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic                        phi2,
  input  logic                        rst,
  mcs6530_bus_master_if.master        bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [9:0]    a_q, a_d;
  logic [7:0]    di_q, di_d;
  logic          we_n_q, we_n_d;
  sel_t          sel_q, sel_d;
  logic          irq_hist_q, irq_hist_d;
  logic          irq_rise_q, irq_rise_d;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    a_d        = a_q;
    di_d       = di_q;
    we_n_d     = we_n_q;
    sel_d      = sel_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d = bus.req_we;
          // ROM is read-only: reject without ever touching the bus.
          if (bus.req_rom && bus.req_we) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 8'h00;
          end else begin
            state_d = DRIVE;
            a_d     = bus.req_addr;
            di_d    = bus.req_wdata;
            sel_d   = bus.req_rom ? SEL_ROM : SEL_RSEL;
            we_n_d  = ~bus.req_we;
          end
        end
      end
      DRIVE: begin
        we_n_d = 1'b1;
        if (we_q) begin
          state_d = RESP;
          sel_d   = SEL_IDLE;
          err_d   = 1'b0;
          rdata_d = 8'h00;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // OE is checked first so data arriving on the final count still wins.
        if (bus.OE) begin
          state_d = RESP;
          rdata_d = bus.DO;
          err_d   = 1'b0;
          sel_d   = SEL_IDLE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d = RESP;
          rdata_d = 8'h00;
          err_d   = 1'b1;
          sel_d   = SEL_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    irq_hist_d  = bus.IRQ;
    irq_rise_d  = bus.IRQ & ~irq_hist_q;
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      a_q         <= 10'h000;
      di_q        <= 8'h00;
      we_n_q      <= 1'b1;
      sel_q       <= SEL_IDLE;
      irq_hist_q  <= 1'b0;
      irq_rise_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      a_q         <= a_d;
      di_q        <= di_d;
      we_n_q      <= we_n_d;
      sel_q       <= sel_d;
      irq_hist_q  <= irq_hist_d;
      irq_rise_q  <= irq_rise_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.A         = a_q;
  assign bus.DI        = di_q;
  assign bus.we_n      = we_n_q;
  assign bus.RS0       = sel_q.rs0;
  assign bus.CS1       = sel_q.cs1;
  assign bus.irq_rise  = irq_rise_q;

endmodule
